// File: rtl/bus_mem_port.sv
// bus_mem_port -- load-side endpoint of the LC-3 datapath bus.
//
// Captures the bus into MAR / MDR and runs one memory access per MIO_EN
// request through a ready handshake with the memory array. R pulses for
// one cycle when the access completes. MDR_OUT feeds the GateMDR bus driver.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   : ACCESS aborts after TIMEOUT_CYCLES cycles without MEM_R.
//               The abort pulses R and sets the sticky ERR flag.
//   Undefined : ACCESS waits for MEM_R indefinitely. ERR is tied to 0.
//
// Ports
//   i_Clk, i_Rst      clock, synchronous active-high reset
//   BUS_IN            datapath bus value
//   LD_MAR, LD_MDR    register loads from the bus (honoured only in IDLE)
//   MIO_EN, R_W       access request (held until R), direction (1 = write)
//   MEM_RDATA, MEM_R  memory read data and ready/acknowledge
//   MAR_OUT, MDR_OUT  register contents
//   MEM_ADDR, MEM_WDATA, MEM_EN, MEM_WE   memory access request
//   R, BUSY, ERR      completion pulse, not-idle flag, sticky timeout flag
module bus_mem_port #(
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic [DATA_W-1:0] BUS_IN,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              R_W,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              MEM_R,
   output logic [DATA_W-1:0] MAR_OUT,
   output logic [DATA_W-1:0] MDR_OUT,
   output logic [DATA_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic              R,
   output logic              BUSY,
   output logic              ERR
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   logic [1:0]        state;
   logic              arm;
   logic [DATA_W-1:0] mar;
   logic [DATA_W-1:0] mdr;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= IDLE;
         arm       <= 1'b1;
         mar       <= '0;
         mdr       <= '0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         MEM_EN    <= 1'b0;
         MEM_WE    <= 1'b0;
         R         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         // A dropped request re-arms; a start needs MIO_EN=1, so the two
         // arm updates never collide.
         if (!MIO_EN)
            arm <= 1'b1;

         case (state)
            IDLE: begin
               if (LD_MAR)
                  mar <= BUS_IN;
               if (LD_MDR)
                  mdr <= BUS_IN;
               // Address/data are taken from the pre-edge registers, so a
               // load on the request edge affects only MAR/MDR.
               if (MIO_EN && arm) begin
                  MEM_ADDR  <= mar;
                  MEM_WDATA <= mdr;
                  MEM_WE    <= R_W;
                  MEM_EN    <= 1'b1;
                  arm       <= 1'b0;
                  state     <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end
            end

            ACCESS: begin
               if (MEM_R) begin
                  if (!MEM_WE)
                     mdr <= MEM_RDATA;
                  MEM_EN <= 1'b0;
                  MEM_WE <= 1'b0;
                  R      <= 1'b1;
                  state  <= DONE;
`ifdef MEM_TIMEOUT_EN
               end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Last allowed ACCESS cycle passed without MEM_R: abort,
                  // leaving MDR untouched.
                  MEM_EN <= 1'b0;
                  MEM_WE <= 1'b0;
                  R      <= 1'b1;
                  err_q  <= 1'b1;
                  state  <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end

            DONE: begin
               R     <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign MAR_OUT = mar;
   assign MDR_OUT = mdr;
   assign BUSY    = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mem_port.sv
// Directed bench for bus_mem_port. A transaction-level reference model
// tracks the expected outputs and is compared on every falling edge. Literal
// expectations from the worked scenarios pin the model.
module tb_bus_mem_port;

   localparam int TMO = 15;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b1;
   logic [15:0] BUS_IN = '0;
   logic        LD_MAR = 1'b0;
   logic        LD_MDR = 1'b0;
   logic        MIO_EN = 1'b0;
   logic        R_W = 1'b0;
   logic [15:0] MEM_RDATA = '0;
   logic        MEM_R = 1'b0;
   logic [15:0] MAR_OUT, MDR_OUT, MEM_ADDR, MEM_WDATA;
   logic        MEM_EN, MEM_WE, R, BUSY, ERR;

   bus_mem_port #(.DATA_W(16), .TIMEOUT_CYCLES(TMO)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .BUS_IN(BUS_IN), .LD_MAR(LD_MAR),
      .LD_MDR(LD_MDR), .MIO_EN(MIO_EN), .R_W(R_W), .MEM_RDATA(MEM_RDATA),
      .MEM_R(MEM_R), .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT),
      .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_EN(MEM_EN),
      .MEM_WE(MEM_WE), .R(R), .BUSY(BUSY), .ERR(ERR)
   );

   always #5 i_Clk = ~i_Clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Phase of the current transaction: 0 idle, 1 access in flight,
   // 2 completion cycle. Updated from the inputs seen at each rising edge.
   int          m_phase;
   bit          m_armed;
   int          m_wait;
   logic [15:0] m_mar, m_mdr, m_addr, m_wdata;
   logic        m_en, m_we, m_r, m_err;
   bit          model_live = 0;

   always @(posedge i_Clk) begin
      logic [15:0] prev_mar, prev_mdr;
      if (i_Rst) begin
         m_phase = 0; m_armed = 1; m_wait = 0;
         m_mar = 0; m_mdr = 0; m_addr = 0; m_wdata = 0;
         m_en = 0; m_we = 0; m_r = 0; m_err = 0;
         model_live = 1;
      end else begin
         prev_mar = m_mar;
         prev_mdr = m_mdr;
         if (m_phase == 0) begin
            if (LD_MAR) m_mar = BUS_IN;
            if (LD_MDR) m_mdr = BUS_IN;
            if (MIO_EN && m_armed) begin
               m_addr = prev_mar; m_wdata = prev_mdr; m_we = R_W;
               m_en = 1; m_armed = 0; m_phase = 1; m_wait = 0;
            end
         end else if (m_phase == 1) begin
            m_wait++;
            if (MEM_R) begin
               if (!m_we) m_mdr = MEM_RDATA;
               m_en = 0; m_we = 0; m_r = 1; m_phase = 2;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_wait >= TMO) begin
               m_en = 0; m_we = 0; m_r = 1; m_err = 1; m_phase = 2;
            end
`endif
         end else begin
            m_r = 0; m_phase = 0;
         end
         if (!MIO_EN) m_armed = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   int r_pulses = 0;
   always @(negedge i_Clk) begin
      if (model_live) begin
         check("MAR_OUT", MAR_OUT, m_mar);
         check("MDR_OUT", MDR_OUT, m_mdr);
         check("MEM_EN", {15'd0, MEM_EN}, {15'd0, m_en});
         check("R", {15'd0, R}, {15'd0, m_r});
         check("BUSY", {15'd0, BUSY}, {15'd0, m_phase != 0});
         check("ERR", {15'd0, ERR}, {15'd0, m_err});
         if (m_en) begin
            check("MEM_ADDR", MEM_ADDR, m_addr);
            check("MEM_WDATA", MEM_WDATA, m_wdata);
            check("MEM_WE", {15'd0, MEM_WE}, {15'd0, m_we});
         end
         if (R === 1'b1) r_pulses++;
      end
   end

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int r0;
      int seen;

      tick(); tick();
      i_Rst = 0;

      // Reset clears a loaded MAR
      BUS_IN = 16'h1234; LD_MAR = 1; tick(); LD_MAR = 0;
      check("lit_mar_loaded", MAR_OUT, 16'h1234);
      i_Rst = 1; tick(); i_Rst = 0;
      check("lit_rst_mar", MAR_OUT, 16'h0000);
      check("lit_rst_busy", {15'd0, BUSY}, 16'h0000);
      check("lit_rst_en", {15'd0, MEM_EN}, 16'h0000);

      // Read with 3-cycle memory latency and busy lockout on LD_MDR
      BUS_IN = 16'h3000; LD_MAR = 1; tick(); LD_MAR = 0;
      r0 = r_pulses;
      MIO_EN = 1; R_W = 0; tick();                 // E0
      check("lit_rd_addr", MEM_ADDR, 16'h3000);
      check("lit_rd_we", {15'd0, MEM_WE}, 16'h0000);
      check("lit_rd_busy", {15'd0, BUSY}, 16'h0001);
      R_W = 1;                                     // ignored after request
      BUS_IN = 16'hAAAA; LD_MDR = 1;
      tick(); tick();                              // E1, E2
      LD_MDR = 0;
      MEM_RDATA = 16'hBEEF; MEM_R = 1; tick();     // E3
      MEM_R = 0; R_W = 0;
      check("lit_rd_r", {15'd0, R}, 16'h0001);
      check("lit_rd_mdr", MDR_OUT, 16'hBEEF);
      tick(); tick(); tick(); tick();              // MIO_EN still high
      check("lit_rd_one_pulse", 16'(r_pulses - r0), 16'd1);
      check("lit_rd_no_reaccess", {15'd0, BUSY}, 16'h0000);
      MIO_EN = 0; tick();

      // Write, ready one cycle after the request
      BUS_IN = 16'h4001; LD_MAR = 1; tick(); LD_MAR = 0;
      BUS_IN = 16'h00FF; LD_MDR = 1; tick(); LD_MDR = 0;
      MIO_EN = 1; R_W = 1; tick();                 // E0
      check("lit_wr_addr", MEM_ADDR, 16'h4001);
      check("lit_wr_data", MEM_WDATA, 16'h00FF);
      check("lit_wr_we", {15'd0, MEM_WE}, 16'h0001);
      MEM_RDATA = 16'h5555; MEM_R = 1; tick();     // E1
      MEM_R = 0;
      check("lit_wr_r_at_2_edges", {15'd0, R}, 16'h0001);
      check("lit_wr_mdr_kept", MDR_OUT, 16'h00FF);
      MIO_EN = 0; tick(); tick();

      // LD_MAR coincident with request start
      BUS_IN = 16'h0010; LD_MAR = 1; tick();
      BUS_IN = 16'h0020; MIO_EN = 1; R_W = 0; tick();   // E0, LD_MAR still 1
      LD_MAR = 0;
      check("lit_sim_addr", MEM_ADDR, 16'h0010);
      check("lit_sim_mar", MAR_OUT, 16'h0020);
      MEM_RDATA = 16'h1357; MEM_R = 1; tick();
      MEM_R = 0; MIO_EN = 0; tick(); tick();

      // MEM_R while idle is ignored
      MEM_RDATA = 16'h9999; MEM_R = 1; tick(); MEM_R = 0; tick();
      check("lit_idle_memr", MDR_OUT, 16'h1357);

      // Reset mid-access: no R pulse
      r0 = r_pulses;
      MIO_EN = 1; tick(); tick();
      i_Rst = 1; tick(); i_Rst = 0; MIO_EN = 0;
      MEM_R = 1; tick(); MEM_R = 0; tick();
      check("lit_rst_mid_no_r", 16'(r_pulses - r0), 16'd0);
      check("lit_rst_mid_busy", {15'd0, BUSY}, 16'h0000);

`ifdef MEM_TIMEOUT_EN
      // Timeout: MEM_R never arrives
      MIO_EN = 1; R_W = 0; tick();                 // E0
      seen = 0;
      for (int i = 1; i <= TMO + 5; i++) begin
         tick();
         if (R === 1'b1) begin seen = i; break; end
      end
      check("lit_tmo_edge", 16'(seen), 16'(TMO));
      check("lit_tmo_err", {15'd0, ERR}, 16'h0001);
      MIO_EN = 0; tick(); tick(); tick();
      check("lit_tmo_err_sticky", {15'd0, ERR}, 16'h0001);
      i_Rst = 1; tick(); i_Rst = 0;
      check("lit_tmo_err_cleared", {15'd0, ERR}, 16'h0000);
`else
      seen = 0;
      check("lit_err_tied", {15'd0, ERR}, 16'(seen));
`endif

      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global guard so a stuck run still terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d expected 0 pending", 1);
      $fatal(1);
   end

endmodule
